rv_axi4_read_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4 read-slave port among `NUM_MASTERS` read-master ports. It is built on the codebase's AXI4 enum and struct types (`rv_axi4_burst`, `rv_axi4_cache`, `rv_axi4_prot`, `rv_axi4_lock`, `rv_axi4_resp`). It sits between core/cache read masters and a shared memory or interconnect slave. Exactly one burst is in flight at a time, and the granted master keeps ownership until the slave's last read beat completes its handshake.

---
 rtl/rv_axi4_read_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_rv_axi4_read_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_axi4_read_arbiter.sv
// rv_axi4_read_arbiter
// Round-robin arbiter sharing one AXI4 read-slave port among NUM_MASTERS
// read masters. Only one burst is in flight at a time. The granted master
// owns the R channel until the slave's last beat completes its handshake.
// Packed AR/R fields use the rv_axi4 encodings (burst, cache, prot, lock,
// resp) bit-for-bit. They are carried here as plain vectors.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | arbitrate; accept the winner's AR and capture its payload
//   ADDR   | present the registered AR to the slave until s_arready
//   DATA   | route R beats between slave and owner until rlast handshake
module rv_axi4_read_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  localparam int GW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  // master AR channels
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_arid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]          m_arlen,
  input  logic [NUM_MASTERS*3-1:0]          m_arsize,
  input  logic [NUM_MASTERS*2-1:0]          m_arburst,
  input  logic [NUM_MASTERS*4-1:0]          m_arcache,
  input  logic [NUM_MASTERS*3-1:0]          m_arprot,
  input  logic [NUM_MASTERS-1:0]            m_arlock,
  // master R channels
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic [ID_WIDTH-1:0]               m_rid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [1:0]                        m_rresp,
  output logic                              m_rlast,
  // slave AR channel
  output logic                              s_arvalid,
  input  logic                              s_arready,
  output logic [ID_WIDTH-1:0]               s_arid,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  output logic [7:0]                        s_arlen,
  output logic [2:0]                        s_arsize,
  output logic [1:0]                        s_arburst,
  output logic [3:0]                        s_arcache,
  output logic [2:0]                        s_arprot,
  output logic                              s_arlock,
  // slave R channel
  input  logic                              s_rvalid,
  output logic                              s_rready,
  input  logic [ID_WIDTH-1:0]               s_rid,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic [1:0]                        s_rresp,
  input  logic                              s_rlast,
  // status
  output logic [GW-1:0]                     grant,
  output logic                              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]            state_q,   state_d;
  logic [GW-1:0]         grant_q,   grant_d;
  logic [GW-1:0]         rr_ptr_q,  rr_ptr_d;
  logic [ID_WIDTH-1:0]   arid_q,    arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [7:0]            arlen_q,   arlen_d;
  logic [2:0]            arsize_q,  arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic [3:0]            arcache_q, arcache_d;
  logic [2:0]            arprot_q,  arprot_d;
  logic                  arlock_q,  arlock_d;

  logic                  found;
  int                    win_idx;
  int                    idx;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    idx     = 0;
    for (int off = 0; off < NUM_MASTERS; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && m_arvalid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Next-state, grant/pointer update and AR payload capture.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arcache_d = arcache_q;
    arprot_d  = arprot_q;
    arlock_d  = arlock_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d   = S_ADDR;
          grant_d   = GW'(win_idx);
          rr_ptr_d  = (win_idx == NUM_MASTERS - 1) ? '0 : GW'(win_idx + 1);
          arid_d    = m_arid[win_idx*ID_WIDTH +: ID_WIDTH];
          araddr_d  = m_araddr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          arlen_d   = m_arlen[win_idx*8 +: 8];
          arsize_d  = m_arsize[win_idx*3 +: 3];
          arburst_d = m_arburst[win_idx*2 +: 2];
          arcache_d = m_arcache[win_idx*4 +: 4];
          arprot_d  = m_arprot[win_idx*3 +: 3];
          arlock_d  = m_arlock[win_idx];
        end
      end
      S_ADDR: begin
        if (s_arready) state_d = S_DATA;
      end
      S_DATA: begin
        // Beats are not counted; rlast alone ends ownership.
        if (s_rvalid && s_rready && s_rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-master handshake steering: AR accept in IDLE, R valid to the owner.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_arready[i] = (state_q == S_IDLE) && found && (win_idx == i);
      m_rvalid[i]  = (state_q == S_DATA) && s_rvalid && (int'(grant_q) == i);
    end
  end

  assign s_rready  = (state_q == S_DATA) && m_rready[grant_q];
  assign s_arvalid = (state_q == S_ADDR);
  assign busy      = (state_q != S_IDLE);
  assign grant     = grant_q;

  assign s_arid    = arid_q;
  assign s_araddr  = araddr_q;
  assign s_arlen   = arlen_q;
  assign s_arsize  = arsize_q;
  assign s_arburst = arburst_q;
  assign s_arcache = arcache_q;
  assign s_arprot  = arprot_q;
  assign s_arlock  = arlock_q;

  // R payload is broadcast; only the owner sees m_rvalid.
  assign m_rid     = s_rid;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;

  // State and AR payload registers; reset abandons any in-flight burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arcache_q <= '0;
      arprot_q  <= '0;
      arlock_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      arcache_q <= arcache_d;
      arprot_q  <= arprot_d;
      arlock_q  <= arlock_d;
    end
  end

endmodule

// File: tb/tb_rv_axi4_read_arbiter.sv
// Testbench for rv_axi4_read_arbiter with three masters.
// Inputs are driven on the falling edge and outputs checked 1 time unit later.
module tb_rv_axi4_read_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_arvalid, m_arready;
  logic [N*IW-1:0] m_arid;
  logic [N*AW-1:0] m_araddr;
  logic [N*8-1:0]  m_arlen;
  logic [N*3-1:0]  m_arsize;
  logic [N*2-1:0]  m_arburst;
  logic [N*4-1:0]  m_arcache;
  logic [N*3-1:0]  m_arprot;
  logic [N-1:0]    m_arlock;
  logic [N-1:0]    m_rvalid, m_rready;
  logic [IW-1:0]   m_rid;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            s_arvalid, s_arready;
  logic [IW-1:0]   s_arid;
  logic [AW-1:0]   s_araddr;
  logic [7:0]      s_arlen;
  logic [2:0]      s_arsize;
  logic [1:0]      s_arburst;
  logic [3:0]      s_arcache;
  logic [2:0]      s_arprot;
  logic            s_arlock;
  logic            s_rvalid, s_rready;
  logic [IW-1:0]   s_rid;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic [1:0]      grant;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  rv_axi4_read_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arcache(m_arcache),
    .m_arprot(m_arprot), .m_arlock(m_arlock),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arcache(s_arcache),
    .s_arprot(s_arprot), .s_arlock(s_arlock),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] mask;
    logic [1:0] exp_g;
    logic [1:0] rresp;
    logic [3:0] rid;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic slot();
    @(negedge clk);
  endtask

  task automatic set_ar(input int i, input logic [31:0] addr, input logic [3:0] id,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                        input logic [3:0] cache, input logic [2:0] prot, input logic lock);
    m_araddr[i*AW +: AW] = addr;
    m_arid[i*IW +: IW]   = id;
    m_arlen[i*8 +: 8]    = len;
    m_arsize[i*3 +: 3]   = size;
    m_arburst[i*2 +: 2]  = burst;
    m_arcache[i*4 +: 4]  = cache;
    m_arprot[i*3 +: 3]   = prot;
    m_arlock[i]          = lock;
  endtask

  task automatic do_reset();
    slot();
    rst_n = 1'b0;
    m_arvalid = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    slot();
    slot();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] tb_addr(input int i, input int k);
    return 32'h4000_0000 + 32'(i * 256) + 32'(k);
  endfunction

  logic [31:0] rx[4];
  int          rc;
  int          nb;
  logic [3:0]  rp;
  logic [2:0]  exp_oh;
  int          g;

  initial begin
    rst_n = 1'b0;
    m_arvalid = '0; m_rready = '1;
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
    m_arburst = '0; m_arcache = '0; m_arprot = '0; m_arlock = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;

    // Vector table: mask of requesters, expected winner, response fields.
    tbl[0] = '{3'b001, 2'd0, 2'b00, 4'h1};
    tbl[1] = '{3'b011, 2'd1, 2'b10, 4'h5};
    tbl[2] = '{3'b011, 2'd0, 2'b11, 4'h2};
    tbl[3] = '{3'b111, 2'd1, 2'b00, 4'h3};
    tbl[4] = '{3'b111, 2'd2, 2'b01, 4'h4};
    tbl[5] = '{3'b110, 2'd1, 2'b00, 4'h6};
    tbl[6] = '{3'b001, 2'd0, 2'b10, 4'h7};
    tbl[7] = '{3'b101, 2'd2, 2'b00, 4'h8};
    tbl[8] = '{3'b100, 2'd2, 2'b11, 4'h9};
    tbl[9] = '{3'b011, 2'd0, 2'b00, 4'hA};

    // ---- reset values ----
    do_reset();
    s_rvalid = 1'b1;
    #1;
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_s_rready",  64'(s_rready), 64'd0);
    chk("rst_m_arready", 64'(m_arready), 64'd0);
    chk("rst_m_rvalid",  64'(m_rvalid), 64'd0);
    chk("rst_grant",     64'(grant), 64'd0);
    chk("rst_s_araddr",  64'(s_araddr), 64'd0);
    s_rvalid = 1'b0;

    // ---- single master, 4-beat INCR burst ----
    slot();
    set_ar(0, 32'h1000, 4'h3, 8'd3, 3'd2, 2'b01, 4'h3, 3'd0, 1'b0);
    m_arvalid = 3'b001;
    #1;
    chk("single_arready", 64'(m_arready), 64'b001);
    chk("single_arvalid_n", 64'(s_arvalid), 64'd0);
    slot();
    m_arvalid = '0;
    s_arready = 1'b1;
    #1;
    chk("single_s_arvalid", 64'(s_arvalid), 64'd1);
    chk("single_s_araddr",  64'(s_araddr), 64'h1000);
    chk("single_s_arlen",   64'(s_arlen), 64'd3);
    chk("single_s_arburst", 64'(s_arburst), 64'b01);
    for (int b = 0; b < 4; b++) begin
      slot();
      s_arready = 1'b0;
      s_rvalid  = 1'b1;
      s_rid     = 4'h3;
      s_rdata   = 32'hA0 + 32'(b);
      s_rlast   = (b == 3);
      #1;
      chk("single_m_rvalid", 64'(m_rvalid), 64'b001);
      chk("single_m_rdata",  64'(m_rdata), 64'hA0 + 64'(b));
    end
    slot();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1;
    chk("single_idle_after", 64'(busy), 64'd0);

    // ---- contention: masters 0 and 1 request continuously ----
    do_reset();
    set_ar(0, 32'h100, 4'h1, 8'd0, 3'd2, 2'b01, 4'h0, 3'd0, 1'b0);
    set_ar(1, 32'h200, 4'h2, 8'd0, 3'd2, 2'b01, 4'h0, 3'd0, 1'b0);
    m_arvalid = 3'b011;
    for (int b = 0; b < 4; b++) begin
      g = b % 2;
      exp_oh = 3'(3'b001 << g);
      #1;
      chk("cont_arready", 64'(m_arready), 64'(exp_oh));
      slot();
      s_arready = 1'b1;
      #1;
      chk("cont_grant_addr", 64'(grant), 64'(g));
      chk("cont_s_araddr",   64'(s_araddr), (g == 0) ? 64'h100 : 64'h200);
      slot();
      s_arready = 1'b0;
      s_rvalid  = 1'b1;
      s_rlast   = 1'b1;
      #1;
      chk("cont_grant_data", 64'(grant), 64'(g));
      chk("cont_m_rvalid",   64'(m_rvalid), 64'(exp_oh));
      chk("cont_arready_hold", 64'(m_arready), 64'd0);
      slot();
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
    end
    m_arvalid = '0;

    // ---- backpressure on AR, then toggling rready on master 1 ----
    slot();
    set_ar(1, 32'h2000, 4'h6, 8'd2, 3'd2, 2'b01, 4'h0, 3'd0, 1'b0);
    m_arvalid = 3'b010;
    #1;
    chk("bp_arready", 64'(m_arready), 64'b010);
    slot();
    m_arvalid = '0;
    set_ar(1, 32'hDEAD_0000, 4'h9, 8'd7, 3'd1, 2'b10, 4'hF, 3'd7, 1'b1);
    s_arready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) slot();
      #1;
      chk("bp_s_arvalid", 64'(s_arvalid), 64'd1);
      chk("bp_s_araddr",  64'(s_araddr), 64'h2000);
      chk("bp_s_arid_len", 64'({s_arid, s_arlen}), 64'h602);
    end
    slot();
    s_arready = 1'b1;
    #1;
    chk("bp_s_arvalid_acc", 64'(s_arvalid), 64'd1);
    rp = 4'b1101;
    nb = 0;
    rc = 0;
    for (int t = 0; t < 4; t++) begin
      slot();
      s_arready = 1'b0;
      s_rvalid  = 1'b1;
      s_rdata   = 32'hB0 + 32'(nb);
      s_rlast   = (nb == 2);
      m_rready  = {1'b1, rp[t], 1'b1};
      #1;
      chk("bp_s_rready", 64'(s_rready), 64'(rp[t]));
      chk("bp_m_rvalid", 64'(m_rvalid), 64'b010);
      if (m_rvalid[1] && m_rready[1] && rc < 4) begin
        rx[rc] = m_rdata;
        rc++;
      end
      if (rp[t]) nb++;
    end
    slot();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = '1;
    #1;
    chk("bp_idle_after", 64'(busy), 64'd0);
    chk("bp_beat_count", 64'(rc), 64'd3);
    for (int j = 0; j < 3; j++) chk("bp_beat_data", 64'(rx[j]), 64'hB0 + 64'(j));

    // ---- table-driven single-beat bursts ----
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++)
        set_ar(i, tb_addr(i, k), 4'(i + 1), 8'(i * 16 + k), 3'(i), 2'b01, 4'(i + 3), 3'(i), i[0]);
      g = int'(tbl[k].exp_g);
      exp_oh = 3'(3'b001 << g);
      m_arvalid = tbl[k].mask;
      #1;
      chk("tbl_arready", 64'(m_arready), 64'(exp_oh));
      slot();
      m_arvalid = '0;
      s_arready = 1'b1;
      #1;
      chk("tbl_grant",    64'(grant), 64'(g));
      chk("tbl_s_araddr", 64'(s_araddr), 64'(tb_addr(g, k)));
      chk("tbl_s_arid",   64'(s_arid), 64'(g + 1));
      chk("tbl_s_arlen",  64'(s_arlen), 64'(g * 16 + k));
      chk("tbl_s_attr",   64'({s_arsize, s_arburst, s_arcache, s_arprot, s_arlock}),
          64'({3'(g), 2'b01, 4'(g + 3), 3'(g), 1'(g % 2)}));
      slot();
      s_arready = 1'b0;
      s_rvalid  = 1'b1;
      s_rlast   = 1'b1;
      s_rid     = tbl[k].rid;
      s_rresp   = tbl[k].rresp;
      s_rdata   = 32'hD000_0000 + 32'(k);
      #1;
      chk("tbl_m_rvalid", 64'(m_rvalid), 64'(exp_oh));
      chk("tbl_m_rresp",  64'(m_rresp), 64'(tbl[k].rresp));
      chk("tbl_m_rid",    64'(m_rid), 64'(tbl[k].rid));
      chk("tbl_m_rdata",  64'(m_rdata), 64'hD000_0000 + 64'(k));
      slot();
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      s_rresp  = 2'b00;
      #1;
      chk("tbl_idle", 64'(busy), 64'd0);
    end

    // ---- reset during DATA after beat 2 of 4 ----
    set_ar(1, 32'h3000, 4'h2, 8'd3, 3'd2, 2'b01, 4'h0, 3'd0, 1'b0);
    m_arvalid = 3'b010;
    #1;
    chk("rstd_arready", 64'(m_arready), 64'b010);
    slot();
    m_arvalid = '0;
    s_arready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      slot();
      s_arready = 1'b0;
      s_rvalid  = 1'b1;
      s_rlast   = 1'b0;
      s_rdata   = 32'hC0 + 32'(b);
      #1;
      chk("rstd_beat_valid", 64'(m_rvalid), 64'b010);
    end
    slot();
    rst_n = 1'b0;
    slot();
    rst_n = 1'b1;
    set_ar(0, 32'h5000, 4'h1, 8'd0, 3'd2, 2'b01, 4'h0, 3'd0, 1'b0);
    set_ar(2, 32'h7000, 4'h3, 8'd0, 3'd2, 2'b01, 4'h0, 3'd0, 1'b0);
    m_arvalid = 3'b101;
    #1;
    chk("rstd_busy",     64'(busy), 64'd0);
    chk("rstd_s_rready", 64'(s_rready), 64'd0);
    chk("rstd_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("rstd_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rstd_m_arready", 64'(m_arready), 64'b001);
    slot();
    m_arvalid = '0;
    s_rvalid  = 1'b0;
    #1;
    chk("rstd_grant",    64'(grant), 64'd0);
    chk("rstd_s_araddr", 64'(s_araddr), 64'h5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
